// File: rtl/sandbox_host_link.sv
// Host-side byte link for the sandbox process interface.
// Assembles 5-byte request frames (control + 32-bit data, LSB first) from
// the host receiver, presents them to the sandbox, and serialises the
// 5-byte response (status + 32-bit data, LSB first) back to the host
// transmitter. Partial frames are abandoned after TIMEOUT_CYCLES idle cycles.
module sandbox_host_link #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        masterClock,
  input  logic        reset,
  input  logic        rxValid,
  input  logic [7:0]  rxByte,
  input  logic        txReady,
  output logic        txValid,
  output logic [7:0]  txByte,
  output logic        dataReceived,
  output logic [7:0]  control,
  output logic [31:0] inputData,
  input  logic        clearDR,
  input  logic        transmitData,
  input  logic [7:0]  status,
  input  logic [31:0] outputData,
  output logic        frameTimeout,
  output logic [7:0]  dropCount
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    RX_COLLECT,
    WAIT_SANDBOX,
    TX_SEND,
    WAIT_RELEASE
  } linkState_t;

  linkState_t  state;
  logic [2:0]  byteIndex;
  logic [15:0] idleCount;
  logic [39:0] respBuffer;

  logic [16:0] idleNext;
  logic        idleExpired;
  logic        lastRxByte;
  logic        lastTxByte;
  logic [2:0]  nextIndex;

  function automatic logic [7:0] pickByte(input logic [39:0] buffer,
                                          input logic [2:0]  sel);
    logic [7:0] result;
    case (sel)
      3'd0:    result = buffer[7:0];
      3'd1:    result = buffer[15:8];
      3'd2:    result = buffer[23:16];
      3'd3:    result = buffer[31:24];
      3'd4:    result = buffer[39:32];
      default: result = '0;
    endcase
    return result;
  endfunction

  // Idle-count arithmetic and frame-position decodes.
  // The timeout fires on the idle cycle that would carry the count to the
  // limit, so an rxValid arriving in that same cycle still wins.
  always_comb begin
    idleNext    = {1'b0, idleCount} + 17'd1;
    idleExpired = (idleNext >= {1'b0, TIMEOUT_LIMIT});
    lastRxByte  = (byteIndex == 3'd4);
    lastTxByte  = (byteIndex == 3'd4);
    nextIndex   = byteIndex + 3'd1;
  end

  // Link FSM: request assembly, sandbox handshake, response serialisation.
  always_ff @(posedge masterClock) begin
    if (reset) begin
      state        <= RX_COLLECT;
      byteIndex    <= '0;
      idleCount    <= '0;
      txValid      <= 1'b0;
      txByte       <= '0;
      dataReceived <= 1'b0;
      control      <= '0;
      inputData    <= '0;
      frameTimeout <= 1'b0;
      respBuffer   <= '0;
    end else begin
      frameTimeout <= 1'b0;
      case (state)
        RX_COLLECT: begin
          if (rxValid) begin
            idleCount <= '0;
            case (byteIndex)
              3'd0:    control         <= rxByte;
              3'd1:    inputData[7:0]   <= rxByte;
              3'd2:    inputData[15:8]  <= rxByte;
              3'd3:    inputData[23:16] <= rxByte;
              default: inputData[31:24] <= rxByte;
            endcase
            if (lastRxByte) begin
              byteIndex    <= '0;
              dataReceived <= 1'b1;
              state        <= WAIT_SANDBOX;
            end else begin
              byteIndex <= nextIndex;
            end
          end else if (byteIndex != 3'd0) begin
            if (idleExpired) begin
              byteIndex    <= '0;
              idleCount    <= '0;
              frameTimeout <= 1'b1;
            end else begin
              idleCount <= idleNext[15:0];
            end
          end else begin
            idleCount <= '0;
          end
        end

        WAIT_SANDBOX: begin
          idleCount <= '0;
          if (transmitData) begin
            respBuffer <= {outputData, status};
            byteIndex  <= '0;
            txValid    <= 1'b1;
            txByte     <= status;
            state      <= TX_SEND;
          end else if (clearDR) begin
            dataReceived <= 1'b0;
            state        <= WAIT_RELEASE;
          end
        end

        TX_SEND: begin
          idleCount <= '0;
          if (clearDR) begin
            dataReceived <= 1'b0;
          end
          if (txValid && txReady) begin
            if (lastTxByte) begin
              txValid   <= 1'b0;
              byteIndex <= '0;
              state     <= WAIT_RELEASE;
            end else begin
              byteIndex <= nextIndex;
              txByte    <= pickByte(respBuffer, nextIndex);
            end
          end
        end

        WAIT_RELEASE: begin
          idleCount <= '0;
          if (clearDR) begin
            dataReceived <= 1'b0;
          end
          if (!dataReceived && !transmitData && !clearDR) begin
            state <= RX_COLLECT;
          end
        end

        default: begin
          state     <= RX_COLLECT;
          byteIndex <= '0;
          idleCount <= '0;
          txValid   <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of host bytes that arrive while no request is being collected.
  always_ff @(posedge masterClock) begin
    if (reset) begin
      dropCount <= '0;
    end else if (rxValid && (state != RX_COLLECT) && (dropCount != 8'hFF)) begin
      dropCount <= dropCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_sandbox_host_link.sv
// Self-checking bench for sandbox_host_link: a transaction-level reference
// model predicts every output; a negedge monitor compares the DUT against it.
module tb_sandbox_host_link;

  localparam int unsigned TO = 8;

  logic        masterClock = 1'b0;
  logic        reset = 1'b1;
  logic        rxValid = 1'b0;
  logic [7:0]  rxByte = '0;
  logic        txReady = 1'b0;
  logic        txValid;
  logic [7:0]  txByte;
  logic        dataReceived;
  logic [7:0]  control;
  logic [31:0] inputData;
  logic        clearDR = 1'b0;
  logic        transmitData = 1'b0;
  logic [7:0]  status = '0;
  logic [31:0] outputData = '0;
  logic        frameTimeout;
  logic [7:0]  dropCount;

  always #5 masterClock = ~masterClock;

  sandbox_host_link #(.TIMEOUT_CYCLES(TO)) dut (
    .masterClock (masterClock),
    .reset       (reset),
    .rxValid     (rxValid),
    .rxByte      (rxByte),
    .txReady     (txReady),
    .txValid     (txValid),
    .txByte      (txByte),
    .dataReceived(dataReceived),
    .control     (control),
    .inputData   (inputData),
    .clearDR     (clearDR),
    .transmitData(transmitData),
    .status      (status),
    .outputData  (outputData),
    .frameTimeout(frameTimeout),
    .dropCount   (dropCount)
  );

  int checks = 0;
  int errors = 0;
  bit monOn  = 1'b0;

  // Reference model state (transaction view of the link).
  bit          mCollect;     // accepting request bytes
  bit          mAwait;       // request presented, sandbox has not answered yet
  bit          mDR;          // expected dataReceived
  int          mPend;        // response bytes not yet accepted by host
  bit          mFT;          // expected frameTimeout this cycle
  int          mDrop;
  int          mIdle;
  logic [7:0]  mCtrl;
  logic [31:0] mData;
  logic [7:0]  part[$];      // bytes of the request being collected
  logic [7:0]  txQ[$];       // scoreboard: response bytes still owed to host
  logic [7:0]  seenTx[$];    // bytes actually handed to host

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mCollect = 1'b1; mAwait = 1'b0; mDR = 1'b0; mPend = 0; mFT = 1'b0;
    mDrop = 0; mIdle = 0; mCtrl = '0; mData = '0;
    part.delete(); txQ.delete();
  endfunction

  // Advance one clock and apply the link rules to the inputs sampled at that edge.
  task automatic step();
    bit r, v, td, cd, tr, drBefore;
    logic [7:0] b, st;
    logic [31:0] od;
    int pendBefore;
    @(posedge masterClock);
    r = reset; v = rxValid; b = rxByte; td = transmitData; cd = clearDR;
    tr = txReady; st = status; od = outputData;
    #1;
    mFT = 1'b0;
    if (r) begin
      modelReset();
    end else begin
      drBefore   = mDR;
      pendBefore = mPend;
      if (mCollect) begin
        if (v) begin
          part.push_back(b);
          mIdle = 0;
          if (part.size() == 5) begin
            mCtrl = part[0];
            mData = {part[4], part[3], part[2], part[1]};
            part.delete();
            mCollect = 1'b0; mAwait = 1'b1; mDR = 1'b1;
          end
        end else if (part.size() > 0) begin
          mIdle++;
          if (mIdle >= int'(TO)) begin
            part.delete(); mIdle = 0; mFT = 1'b1;
          end
        end else begin
          mIdle = 0;
        end
      end else begin
        if (v && mDrop < 255) mDrop++;
        if (mAwait && td) begin
          txQ.push_back(st);
          txQ.push_back(od[7:0]);
          txQ.push_back(od[15:8]);
          txQ.push_back(od[23:16]);
          txQ.push_back(od[31:24]);
          mPend = 5; mAwait = 1'b0;
        end else if (cd) begin
          mDR = 1'b0; mAwait = 1'b0;
        end
        if (pendBefore > 0 && tr) begin
          void'(txQ.pop_front());
          mPend--;
        end
        if (!mAwait && !drBefore && pendBefore == 0 && !td && !cd) mCollect = 1'b1;
      end
    end
  endtask

  // Monitor: compare every observable output with the model each cycle.
  always @(negedge masterClock) begin
    if (monOn) begin
      check("txValid", 64'(txValid), 64'(mPend > 0));
      if (mPend > 0 && txQ.size() > 0) check("txByte", 64'(txByte), 64'(txQ[0]));
      if (txValid && txReady) seenTx.push_back(txByte);
      check("dataReceived", 64'(dataReceived), 64'(mDR));
      if (mDR) begin
        check("control", 64'(control), 64'(mCtrl));
        check("inputData", 64'(inputData), 64'(mData));
      end
      check("frameTimeout", 64'(frameTimeout), 64'(mFT));
      check("dropCount", 64'(dropCount), 64'(mDrop));
    end
  end

  task automatic sendByte(input logic [7:0] b);
    rxValid = 1'b1; rxByte = b;
    step();
    rxValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic sendFive(input logic [7:0] b0, b1, b2, b3, b4);
    sendByte(b0); sendByte(b1); sendByte(b2); sendByte(b3); sendByte(b4);
  endtask

  task automatic releaseWait();
    for (int i = 0; i < 6 && !mCollect; i++) step();
  endtask

  task automatic respond(input logic [7:0] st, input logic [31:0] od, input int readyPct,
                         input int clrAt, input bit stall10, input bit resetOn3rd);
    int cyc;
    int stalled;
    bit done;
    cyc = 0; stalled = 0; done = 1'b0;
    status = st; outputData = od; transmitData = 1'b1;
    step();
    transmitData = 1'b0; status = 8'($urandom); outputData = $urandom;
    while (!done && cyc < 400) begin
      if (resetOn3rd && mPend == 3) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        done = 1'b1;
      end else begin
        if (stall10 && mPend == 4 && stalled < 10) begin
          txReady = 1'b0;
          stalled++;
        end else begin
          txReady = (int'($urandom_range(99)) < readyPct);
        end
        clearDR = mDR && (cyc >= clrAt || mPend == 0);
        step();
        clearDR = 1'b0;
        cyc++;
        if (mPend == 0 && !mDR) done = 1'b1;
      end
    end
    txReady = 1'b0;
    check("respond completes within budget", 64'(done), 64'd1);
  endtask

  task automatic sendRandomFrame();
    int gap;
    int n;
    n = 0;
    while (mCollect && n < 80) begin
      gap = ($urandom_range(7) == 0) ? int'(TO) + int'($urandom_range(3))
                                     : int'($urandom_range(TO - 1));
      idle(gap);
      sendByte(8'($urandom));
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp22[5];
    logic [7:0] exp23[5];
    modelReset();
    step();
    step();
    check("reset txValid", 64'(txValid), 64'd0);
    check("reset txByte", 64'(txByte), 64'd0);
    check("reset dataReceived", 64'(dataReceived), 64'd0);
    check("reset control", 64'(control), 64'd0);
    check("reset inputData", 64'(inputData), 64'd0);
    check("reset frameTimeout", 64'(frameTimeout), 64'd0);
    check("reset dropCount", 64'(dropCount), 64'd0);
    reset = 1'b0;
    monOn = 1'b1;

    // Basic request / response.
    sendFive(8'h01, 8'h78, 8'h56, 8'h34, 8'h12);
    check("req control", 64'(control), 64'h01);
    check("req inputData", 64'(inputData), 64'h12345678);
    check("req dataReceived", 64'(dataReceived), 64'd1);
    seenTx.delete();
    respond(8'h01, 32'hAABBCCDD, 100, 1000, 1'b0, 1'b0);
    exp22 = '{8'h01, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    check("resp byte count", 64'(seenTx.size()), 64'd5);
    for (int i = 0; i < 5; i++) check("resp byte", 64'(seenTx[i]), 64'(exp22[i]));
    releaseWait();

    // Backpressure on the second response byte, clearDR mid-transmission.
    sendFive(8'h02, 8'h44, 8'h33, 8'h22, 8'h11);
    seenTx.delete();
    respond(8'h5A, 32'h11223344, 100, 2, 1'b1, 1'b0);
    exp23 = '{8'h5A, 8'h44, 8'h33, 8'h22, 8'h11};
    check("stall byte count", 64'(seenTx.size()), 64'd5);
    for (int i = 0; i < 5; i++) check("stall byte", 64'(seenTx[i]), 64'(exp23[i]));
    releaseWait();

    // Timeout boundary: one idle cycle short of the limit keeps the frame.
    sendByte(8'h33); sendByte(8'h01);
    idle(TO - 1);
    sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
    check("no-timeout control", 64'(control), 64'h33);
    check("no-timeout inputData", 64'(inputData), 64'h04030201);
    step();
    clearDR = 1'b1; step(); clearDR = 1'b0;
    releaseWait();

    // Timeout: partial frame abandoned after TO idle cycles.
    sendByte(8'hAA); sendByte(8'hBB);
    idle(TO);
    check("timeout pulse", 64'(frameTimeout), 64'd1);
    step();
    check("timeout single pulse", 64'(frameTimeout), 64'd0);
    sendFive(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
    check("post-timeout control", 64'(control), 64'h11);
    check("post-timeout inputData", 64'(inputData), 64'h55443322);
    step();
    clearDR = 1'b1; step(); clearDR = 1'b0;
    releaseWait();

    // Overrun while waiting on the sandbox.
    sendFive(8'hC3, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
    repeat (300) sendByte(8'($urandom));
    check("overrun dropCount", 64'(dropCount), 64'd255);
    check("overrun control", 64'(control), 64'hC3);
    check("overrun inputData", 64'(inputData), 64'hDEADBEEF);

    // Reset during the third response byte.
    respond(8'h77, 32'h01020304, 100, 1000, 1'b0, 1'b1);
    check("midtx reset txValid", 64'(txValid), 64'd0);
    check("midtx reset txByte", 64'(txByte), 64'd0);
    check("midtx reset dataReceived", 64'(dataReceived), 64'd0);
    check("midtx reset control", 64'(control), 64'd0);
    check("midtx reset inputData", 64'(inputData), 64'd0);
    check("midtx reset frameTimeout", 64'(frameTimeout), 64'd0);
    check("midtx reset dropCount", 64'(dropCount), 64'd0);
    idle(6);

    // Randomised traffic.
    for (int it = 0; it < 30; it++) begin
      sendRandomFrame();
      repeat ($urandom_range(3)) sendByte(8'($urandom));
      if ($urandom_range(3) == 0) begin
        idle(int'($urandom_range(2)));
        clearDR = 1'b1; step(); clearDR = 1'b0;
      end else begin
        respond(8'($urandom), $urandom, 40 + int'($urandom_range(60)),
                int'($urandom_range(8)), 1'b0, 1'b0);
      end
      releaseWait();
    end
    idle(3);

    monOn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
